// File: rtl/movegen_pos_sched.sv
// Round-robin position scheduler: streams one granted board's 64 squares
// from shared board RAM as a sop/eop beat stream, with an idle gap between positions.
module movegen_pos_sched #(
  parameter int NUM_REQ    = 2,
  parameter int BOARD_ID_W = 4,
  parameter int PIECE_W    = 4,
  parameter int GAP_CYCLES = 1,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*BOARD_ID_W-1:0] req_board_id,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          mem_rd_en,
  output logic [BOARD_ID_W+5:0]         mem_rd_addr,
  input  logic [PIECE_W-1:0]            mem_rd_data,
  input  logic                          out_hold,
  output logic                          out_pos_valid,
  output logic                          out_pos_sop,
  output logic                          out_pos_eop,
  output logic [PIECE_W-1:0]            out_pos_data,
  output logic [OW-1:0]                 out_pos_owner
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    GAP
  } state_t;

  localparam logic [3:0] GAP_LAST =
    4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                state_q, state_d;
  logic [5:0]            sq_q, sq_d;
  logic [BOARD_ID_W-1:0] bid_q, bid_d;
  logic [OW-1:0]         own_q, own_d;
  logic [OW-1:0]         rr_q, rr_d;
  logic [3:0]            gap_q, gap_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  vld_q, vld_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic [OW-1:0]         vown_q, vown_d;

  logic [2*NUM_REQ-1:0]  req2;
  logic [NUM_REQ-1:0]    rot;
  logic [OW:0]           sum;
  logic [OW:0]           nxt;
  logic [OW-1:0]         pick;
  logic [OW-1:0]         rr_nxt;
  logic                  pick_ok;
  logic [BOARD_ID_W-1:0] bid_sel;
  logic                  issue;

  // Rotate so bit 0 is the requester at rr_q; lowest set bit wins.
  assign req2 = {req, req};
  assign rot  = NUM_REQ'(req2 >> rr_q);

  always_comb begin
    pick_ok = 1'b0;
    sum     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick_ok = 1'b1;
        sum     = {1'b0, rr_q} + (OW+1)'(k);
      end
    end
    if (sum >= (OW+1)'(NUM_REQ))
      sum = sum - (OW+1)'(NUM_REQ);
    pick   = sum[OW-1:0];
    nxt    = {1'b0, pick} + (OW+1)'(1);
    rr_nxt = (nxt >= (OW+1)'(NUM_REQ)) ? '0 : nxt[OW-1:0];
    bid_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == OW'(k))
        bid_sel = req_board_id[k*BOARD_ID_W +: BOARD_ID_W];
    end
  end

  assign issue = (state_q == STREAM) && !out_hold && !rst;

  always_comb begin
    state_d = state_q;
    sq_d    = sq_q;
    bid_d   = bid_q;
    own_d   = own_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    grant_d = '0;
    done_d  = '0;
    vld_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    vown_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d = STREAM;
          grant_d = NUM_REQ'(1) << pick;
          bid_d   = bid_sel;
          own_d   = pick;
          rr_d    = rr_nxt;
          sq_d    = '0;
        end
      end
      STREAM: begin
        if (issue) begin
          sq_d   = sq_q + 6'd1;
          vld_d  = 1'b1;
          sop_d  = (sq_q == 6'd0);
          eop_d  = (sq_q == 6'd63);
          vown_d = own_q;
          if (sq_q == 6'd63) begin
            state_d = DRAIN;
            done_d  = NUM_REQ'(1) << own_q;
          end
        end
      end
      DRAIN: begin
        gap_d   = '0;
        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_q == GAP_LAST)
          state_d = IDLE;
        else
          gap_d = gap_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sq_q    <= '0;
      bid_q   <= '0;
      own_q   <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      vown_q  <= '0;
    end else begin
      state_q <= state_d;
      sq_q    <= sq_d;
      bid_q   <= bid_d;
      own_q   <= own_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      vown_q  <= vown_d;
    end
  end

  assign grant         = grant_q;
  assign done          = done_q;
  assign mem_rd_en     = issue;
  assign mem_rd_addr   = issue ? {bid_q, sq_q} : '0;
  assign out_pos_valid = vld_q;
  assign out_pos_sop   = sop_q;
  assign out_pos_eop   = eop_q;
  // RAM data lands in the beat cycle; gate it so idle cycles read as zero.
  assign out_pos_data  = vld_q ? mem_rd_data : '0;
  assign out_pos_owner = vown_q;

endmodule

// File: tb/tb_movegen_pos_sched.sv
// Directed bench for movegen_pos_sched: table-checked single stream plus
// alternation, hold, reset, zero-gap and withdrawn-request sequences.
module tb_movegen_pos_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_a = '0, req_b = '0;
  logic [7:0] bid_a = '0, bid_b = '0;
  logic [1:0] grant_a, done_a, grant_b, done_b;
  logic       rd_en_a, rd_en_b;
  logic [9:0] addr_a, addr_b;
  logic [3:0] rdata_a = '0, rdata_b = '0;
  logic       hold_a = 1'b0, hold_b = 1'b0;
  logic       vld_a, sop_a, eop_a, vld_b, sop_b, eop_b;
  logic [3:0] data_a, data_b;
  logic       own_a, own_b;

  logic [3:0] ram [0:1023];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         off;
    logic [1:0] grant;
    logic       rd;
    logic [9:0] addr;
    logic       vld;
    logic       sop;
    logic       eop;
    logic [1:0] done;
  } vec_t;
  localparam int NTAB = 8;
  vec_t tab [NTAB];

  always #5 clk = ~clk;

  movegen_pos_sched #(.NUM_REQ(2), .BOARD_ID_W(4), .PIECE_W(4),
                      .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_board_id(bid_a),
    .grant(grant_a), .done(done_a), .mem_rd_en(rd_en_a),
    .mem_rd_addr(addr_a), .mem_rd_data(rdata_a), .out_hold(hold_a),
    .out_pos_valid(vld_a), .out_pos_sop(sop_a), .out_pos_eop(eop_a),
    .out_pos_data(data_a), .out_pos_owner(own_a));

  movegen_pos_sched #(.NUM_REQ(2), .BOARD_ID_W(4), .PIECE_W(4),
                      .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_board_id(bid_b),
    .grant(grant_b), .done(done_b), .mem_rd_en(rd_en_b),
    .mem_rd_addr(addr_b), .mem_rd_data(rdata_b), .out_hold(hold_b),
    .out_pos_valid(vld_b), .out_pos_sop(sop_b), .out_pos_eop(eop_b),
    .out_pos_data(data_b), .out_pos_owner(own_b));

  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= ram[addr_a];
    if (rd_en_b) rdata_b <= ram[addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_a = '0; req_b = '0; hold_a = 1'b0; hold_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_a(output int n);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (grant_a != 2'b00) begin
        n = i;
        break;
      end
    end
  endtask

  // Called at the negedge of the grant cycle (offset 0).
  task automatic run_a(input int bid, input int hs, input int hn,
                       input int pulse, input int last, input bit use_tab);
    int nb, nr, eop_off, done_off, xg;
    logic [3:0] b4;
    b4 = 4'(bid);
    nb = 0; nr = 0; eop_off = -1; done_off = -1; xg = 0;
    for (int off = 0; off <= last; off++) begin
      if (off > 0) begin
        @(posedge clk); #1;
        req_a  = (off == pulse) ? 2'b10 : 2'b00;
        hold_a = (off >= hs) && (off < hs + hn);
        @(negedge clk);
        if (grant_a != 2'b00) xg++;
      end
      if (rd_en_a) begin
        chk("rd_addr", 32'(addr_a), 32'({b4, 6'(nr)}));
        nr++;
      end
      if (hold_a) chk("hold_no_read", 32'(rd_en_a), 0);
      if (hn > 0 && off == hs) chk("beat_in_hold", 32'(vld_a), 1);
      if (vld_a) begin
        chk("beat_data", 32'(data_a), 32'(ram[{b4, 6'(nb)}]));
        chk("beat_sop", 32'(sop_a), 32'(nb == 0));
        chk("beat_eop", 32'(eop_a), 32'(nb == 63));
        chk("beat_owner", 32'(own_a), 0);
        if (eop_a) eop_off = off;
        nb++;
      end
      if (done_a != 2'b00) begin
        chk("done_onehot", 32'(done_a), 32'(2'b01));
        done_off = off;
      end
      if (use_tab) begin
        for (int e = 0; e < NTAB; e++) begin
          if (tab[e].off == off) begin
            chk("tab_grant", 32'(grant_a), 32'(tab[e].grant));
            chk("tab_rd_en", 32'(rd_en_a), 32'(tab[e].rd));
            chk("tab_addr",  32'(addr_a),  32'(tab[e].addr));
            chk("tab_valid", 32'(vld_a),   32'(tab[e].vld));
            chk("tab_sop",   32'(sop_a),   32'(tab[e].sop));
            chk("tab_eop",   32'(eop_a),   32'(tab[e].eop));
            chk("tab_done",  32'(done_a),  32'(tab[e].done));
          end
        end
      end
    end
    hold_a = 1'b0;
    req_a  = '0;
    chk("beat_count", 32'(nb), 64);
    chk("read_count", 32'(nr), 64);
    chk("eop_cycle", 32'(eop_off), 32'(64 + hn));
    chk("done_cycle", 32'(done_off), 32'(64 + hn));
    chk("no_extra_grant", 32'(xg), 0);
  endtask

  initial begin
    int n;
    int ng, ns, ne, vcnt;
    int g_cyc [4];
    logic [1:0] g_val [4];
    logic own_s [4];
    logic [3:0] dat_s [4];
    int eop_cyc;

    for (int i = 0; i < 1024; i++) ram[i] = 4'($urandom);
    tab[0] = '{0,  2'b01, 1'b1, 10'h0C0, 1'b0, 1'b0, 1'b0, 2'b00};
    tab[1] = '{1,  2'b00, 1'b1, 10'h0C1, 1'b1, 1'b1, 1'b0, 2'b00};
    tab[2] = '{2,  2'b00, 1'b1, 10'h0C2, 1'b1, 1'b0, 1'b0, 2'b00};
    tab[3] = '{40, 2'b00, 1'b1, 10'h0E8, 1'b1, 1'b0, 1'b0, 2'b00};
    tab[4] = '{63, 2'b00, 1'b1, 10'h0FF, 1'b1, 1'b0, 1'b0, 2'b00};
    tab[5] = '{64, 2'b00, 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 2'b01};
    tab[6] = '{65, 2'b00, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 2'b00};
    tab[7] = '{66, 2'b00, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 2'b00};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_grant", 32'(grant_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_rd_en", 32'(rd_en_a), 0);
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_valid", 32'(vld_a), 0);
    chk("rst_data", 32'(data_a), 0);
    chk("rst_owner", 32'(own_a), 0);
    chk("rst_b_valid", 32'(vld_b), 0);
    chk("rst_b_rd_en", 32'(rd_en_b), 0);
    @(posedge clk); #1;

    // Single stream, board 3, table-checked
    bid_a = {4'd0, 4'd3};
    req_a = 2'b01;
    wait_a(n);
    chk("t1_grant_lat", 32'(n), 1);
    run_a(3, 1000, 0, -1, 68, 1'b1);

    // Both requesting: alternation and spacing
    do_reset();
    bid_a = {4'd2, 4'd1};
    req_a = 2'b11;
    ng = 0; ns = 0;
    for (int k = 0; k < 4; k++) begin
      g_cyc[k] = 0; g_val[k] = '0; own_s[k] = 1'b0; dat_s[k] = '0;
    end
    for (int i = 1; i <= 260; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (grant_a != 2'b00 && ng < 4) begin
        g_val[ng] = grant_a; g_cyc[ng] = i; ng++;
      end
      if (vld_a && sop_a && ns < 4) begin
        own_s[ns] = own_a; dat_s[ns] = data_a; ns++;
      end
    end
    req_a = '0;
    chk("t2_grants", 32'(ng), 4);
    chk("t2_sops", 32'(ns), 4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant_val", 32'(g_val[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("t2_owner", 32'(own_s[k]), 32'(k % 2));
      chk("t2_sop_data", 32'(dat_s[k]),
          32'(ram[(k % 2 == 0) ? 10'h040 : 10'h080]));
      if (k > 0) chk("t2_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 67);
    end

    // Hold for 5 cycles right after the square-10 read
    do_reset();
    bid_a = {4'd0, 4'd5};
    req_a = 2'b01;
    wait_a(n);
    chk("t3_grant_lat", 32'(n), 1);
    run_a(5, 11, 5, -1, 72, 1'b0);

    // Reset on the square-30 beat
    do_reset();
    bid_a = {4'd9, 4'd6};
    req_a = 2'b01;
    wait_a(n);
    chk("t4_grant", 32'(grant_a), 1);
    for (int off = 1; off <= 31; off++) begin
      @(posedge clk); #1;
      req_a = '0;
      if (off == 31) rst = 1'b1;
      @(negedge clk);
    end
    chk("t4_sq30_valid", 32'(vld_a), 1);
    chk("t4_sq30_data", 32'(data_a), 32'(ram[10'h19E]));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_post_valid", 32'(vld_a), 0);
    chk("t4_post_sop", 32'(sop_a), 0);
    chk("t4_post_eop", 32'(eop_a), 0);
    chk("t4_post_done", 32'(done_a), 0);
    chk("t4_post_grant", 32'(grant_a), 0);
    chk("t4_post_rd_en", 32'(rd_en_a), 0);
    chk("t4_post_addr", 32'(addr_a), 0);
    chk("t4_post_data", 32'(data_a), 0);
    vcnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (vld_a || done_a != 2'b00 || rd_en_a) vcnt++;
    end
    chk("t4_abandoned", 32'(vcnt), 0);
    req_a = 2'b11;
    wait_a(n);
    chk("t4_rr_reset", 32'(grant_a), 1);
    @(posedge clk); #1;
    req_a = '0;
    @(negedge clk);
    chk("t4_fresh_sop", 32'(sop_a), 1);
    chk("t4_fresh_valid", 32'(vld_a), 1);
    chk("t4_fresh_data", 32'(data_a), 32'(ram[10'h180]));

    // One-cycle req[1] pulse mid-stream is never granted
    do_reset();
    bid_a = {4'd8, 4'd7};
    req_a = 2'b01;
    wait_a(n);
    chk("t6_grant", 32'(grant_a), 1);
    run_a(7, 1000, 0, 20, 80, 1'b0);

    // Zero gap: back-to-back streams for requester 1
    do_reset();
    bid_b = {4'd4, 4'd0};
    req_b = 2'b10;
    ng = 0; ne = 0; ns = 0; eop_cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (grant_b != 2'b00 && ng < 2) begin
        g_val[ng] = grant_b; g_cyc[ng] = i; ng++;
      end
      if (eop_b && ne < 1) begin
        eop_cyc = i; ne++;
      end
      if (vld_b && sop_b && ns < 1) begin
        own_s[0] = own_b; dat_s[0] = data_b; ns++;
      end
    end
    req_b = '0;
    chk("t5_grants", 32'(ng), 2);
    chk("t5_grant0", 32'(g_val[0]), 2);
    chk("t5_grant1", 32'(g_val[1]), 2);
    chk("t5_eop_lat", 32'(eop_cyc - g_cyc[0]), 64);
    chk("t5_regrant", 32'(g_cyc[1] - eop_cyc), 2);
    chk("t5_owner", 32'(own_s[0]), 1);
    chk("t5_sop_data", 32'(dat_s[0]), 32'(ram[10'h100]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
